// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: counting modes, count direction
// and the default datapath sizes.
package pwm_pkg;

   localparam int PWM_WIDTH    = 8;
   localparam int PWM_CHANNELS = 3;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: edge- or centre-aligned counter with its active period
// and mode, updated only at a wrap so every period is complete.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             apply,
   input  logic [WIDTH-1:0] period_new,
   input  logic             mode_new,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             cycle_start
);

   logic [WIDTH-1:0] count_q, count_d, count_nxt;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   dir_e             dir_q, dir_d, dir_nxt;

   always_comb begin
      count_nxt = count_q + WIDTH'(1);
      dir_nxt   = dir_q;
      if (mode_q == MODE_EDGE) begin
         dir_nxt = DIR_UP;
         if (count_q == period_q) count_nxt = '0;
      end else if (period_q == '0) begin
         count_nxt = '0;
      end else if (dir_q == DIR_DOWN) begin
         count_nxt = count_q - WIDTH'(1);
      end else if (count_q == period_q) begin
         count_nxt = count_q - WIDTH'(1);
         dir_nxt   = DIR_DOWN;
      end
      // Reaching zero always restarts counting upward (covers period 1 in centre mode).
      if (count_nxt == '0) dir_nxt = DIR_UP;

      wrap     = !enable || (count_nxt == '0);
      count_d  = enable ? count_nxt : '0;
      dir_d    = enable ? dir_nxt : DIR_UP;
      period_d = period_q;
      mode_d   = mode_q;
      if (wrap && apply) begin
         period_d = period_new;
         mode_d   = mode_new;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         dir_q    <= DIR_UP;
         period_q <= '0;
         mode_q   <= MODE_EDGE;
      end else begin
         count_q  <= count_d;
         dir_q    <= dir_d;
         period_q <= period_d;
         mode_q   <= mode_d;
      end
   end

   assign count       = count_q;
   assign cycle_start = enable && !reset && (count_q == '0);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase, double-buffered levels/period/mode
// applied only at a wrap, and one registered compare output per channel.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int                     WIDTH       = PWM_WIDTH,
   parameter int                     CHANNELS    = PWM_CHANNELS,
   parameter logic [CHANNELS-1:0]    INVERT_MASK = {CHANNELS{1'b0}}
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      load,
   input  logic [CHANNELS*WIDTH-1:0] level_in,
   input  logic [WIDTH-1:0]          period_in,
   input  logic                      center_in,
   output logic [CHANNELS-1:0]       out,
   output logic                      cycle_start,
   output logic                      update_pending
);

   logic [CHANNELS*WIDTH-1:0] level_act_q, level_act_d;
   logic [CHANNELS*WIDTH-1:0] level_sh_q, level_sh_d;
   logic [WIDTH-1:0]          period_sh_q, period_sh_d;
   logic                      mode_sh_q, mode_sh_d;
   logic                      pending_q, pending_d;
   logic [CHANNELS-1:0]       out_q, out_d;

   logic [WIDTH-1:0]          count;
   logic                      wrap;
   logic                      apply;
   logic [CHANNELS*WIDTH-1:0] level_new;
   logic [WIDTH-1:0]          period_new;
   logic                      mode_new;

   // A load in the wrap cycle bypasses the shadow and goes straight to active.
   assign apply      = load || pending_q;
   assign level_new  = load ? level_in  : level_sh_q;
   assign period_new = load ? period_in : period_sh_q;
   assign mode_new   = load ? center_in : mode_sh_q;

   pwm_timebase #(
      .WIDTH (WIDTH)
   ) u_timebase (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .apply       (apply),
      .period_new  (period_new),
      .mode_new    (mode_new),
      .count       (count),
      .wrap        (wrap),
      .cycle_start (cycle_start)
   );

   always_comb begin
      level_act_d = level_act_q;
      level_sh_d  = level_sh_q;
      period_sh_d = period_sh_q;
      mode_sh_d   = mode_sh_q;
      pending_d   = pending_q;
      if (wrap) begin
         if (apply) level_act_d = level_new;
         pending_d = 1'b0;
      end
      if (load) begin
         level_sh_d  = level_in;
         period_sh_d = period_in;
         mode_sh_d   = center_in;
         if (!wrap) pending_d = 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign out_d[i] = enable && ((count < level_act_q[i*WIDTH +: WIDTH]) ^ INVERT_MASK[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_act_q <= '0;
         level_sh_q  <= '0;
         period_sh_q <= '0;
         mode_sh_q   <= MODE_EDGE;
         pending_q   <= 1'b0;
         out_q       <= '0;
      end else begin
         level_act_q <= level_act_d;
         level_sh_q  <= level_sh_d;
         period_sh_q <= period_sh_d;
         mode_sh_q   <= mode_sh_d;
         pending_q   <= pending_d;
         out_q       <= out_d;
      end
   end

   assign out            = out_q;
   assign update_pending = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-phase reference model predicts
// out, cycle_start and update_pending for every cycle of directed and random stimulus.
module tb_pwm_multi;

   localparam int         W    = 8;
   localparam int         CH   = 3;
   localparam logic [2:0] MASK = 3'b100;

   logic          clk = 1'b0;
   logic          reset, enable, load, center_in;
   logic [CH*W-1:0] level_in;
   logic [W-1:0]  period_in;
   logic [CH-1:0] out;
   logic          cycle_start, update_pending;

   always #5 clk = ~clk;

   pwm_multi #(
      .WIDTH       (W),
      .CHANNELS    (CH),
      .INVERT_MASK (MASK)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .load           (load),
      .level_in       (level_in),
      .period_in      (period_in),
      .center_in      (center_in),
      .out            (out),
      .cycle_start    (cycle_start),
      .update_pending (update_pending)
   );

   typedef struct {
      logic [CH-1:0] out;
      logic          cs;
      logic          up;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: position within the period (phase) plus active/shadow settings.
   int            m_t, m_pa, m_mode, m_sp, m_smode;
   int            m_la[CH];
   int            m_sla[CH];
   bit            m_pend;
   logic [CH-1:0] m_out;

   function automatic int m_len();
      if (m_mode == 0) return m_pa + 1;
      return (m_pa == 0) ? 1 : 2 * m_pa;
   endfunction

   function automatic int m_count();
      if (m_mode == 0 || m_t <= m_pa) return m_t;
      return 2 * m_pa - m_t;
   endfunction

   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic model_edge(input bit rst, input bit en, input bit ld,
                             input logic [CH*W-1:0] lvl, input int per, input bit ctr);
      bit wrap;
      int c;
      if (rst) begin
         m_t = 0; m_pa = 0; m_mode = 0; m_sp = 0; m_smode = 0; m_pend = 0; m_out = '0;
         for (int i = 0; i < CH; i++) begin m_la[i] = 0; m_sla[i] = 0; end
         return;
      end
      c = m_count();
      for (int i = 0; i < CH; i++) m_out[i] = en ? ((c < m_la[i]) ^ MASK[i]) : 1'b0;
      wrap = !en || (m_t == m_len() - 1);
      if (wrap) begin
         m_t = 0;
         if (ld) begin
            m_pa = per; m_mode = ctr;
            for (int i = 0; i < CH; i++) m_la[i] = int'(lvl[i*W +: W]);
         end else if (m_pend) begin
            m_pa = m_sp; m_mode = m_smode;
            for (int i = 0; i < CH; i++) m_la[i] = m_sla[i];
         end
         m_pend = 0;
      end else begin
         m_t++;
      end
      if (ld && !wrap) begin
         m_sp = per; m_smode = ctr; m_pend = 1;
         for (int i = 0; i < CH; i++) m_sla[i] = int'(lvl[i*W +: W]);
      end
   endtask

   task automatic step(input bit rst, input bit en, input bit ld,
                       input logic [CH*W-1:0] lvl, input int per, input bit ctr, input bit chk);
      exp_t e;
      @(negedge clk);
      reset = rst; enable = en; load = ld; level_in = lvl;
      period_in = per[W-1:0]; center_in = ctr;
      if (chk) begin
         e.out = m_out;
         e.cs  = en && !rst && (m_t == 0);
         e.up  = m_pend;
         exp_q.push_back(e);
      end
      model_edge(rst, en, ld, lvl, per, ctr);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, CH*W'($urandom), $urandom % 256, $urandom % 2, 1'b1);
   endtask

   task automatic wait_phase(input bit at_wrap, input int phase);
      int guard = 0;
      while (at_wrap ? (m_t != m_len() - 1) : (m_t != phase)) begin
         if (guard == 1200) begin
            checks++;
            $display("FAIL wait_phase: phase %0d not reached, model t=%0d", phase, m_t);
            return;
         end
         idle(1);
         guard++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", out, e.out);
            check("cycle_start", {2'b00, cycle_start}, {2'b00, e.cs});
            check("update_pending", {2'b00, update_pending}, {2'b00, e.up});
         end
      end
   end

   initial begin : driver
      logic [CH*W-1:0] lvl;
      reset = 1'b1; enable = 1'b0; load = 1'b0; level_in = '0; period_in = '0; center_in = 1'b0;
      model_edge(1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);

      // Edge mode, P=9, levels {200,5,0}
      step(1'b0, 1'b1, 1'b1, {8'd200, 8'd5, 8'd0}, 9, 1'b0, 1'b1);
      idle(35);
      // Mid-period level change is deferred to the next period
      wait_phase(1'b0, 4);
      step(1'b0, 1'b1, 1'b1, {8'd200, 8'd3, 8'd0}, 9, 1'b0, 1'b1);
      idle(30);
      // Centre mode, P=4, ch0=2
      step(1'b0, 1'b1, 1'b1, {8'd200, 8'd3, 8'd2}, 4, 1'b1, 1'b1);
      idle(30);
      // Inverted channel, then reset mid-period
      step(1'b0, 1'b1, 1'b1, {8'd3, 8'd5, 8'd0}, 9, 1'b0, 1'b1);
      idle(25);
      wait_phase(1'b0, 6);
      step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, {8'd3, 8'd5, 8'd0}, 9, 1'b0, 1'b1);
      idle(25);
      // Load exactly on the wrap cycle
      wait_phase(1'b1, 0);
      step(1'b0, 1'b1, 1'b1, {8'd7, 8'd5, 8'd0}, 9, 1'b0, 1'b1);
      idle(25);
      // Disable mid-period, load while disabled, re-enable
      wait_phase(1'b0, 5);
      step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, {8'd2, 8'd1, 8'd3}, 3, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
      idle(20);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < CH; i++) lvl[i*W +: W] = ($urandom % 4 == 0) ? 8'd255 : W'($urandom % 16);
         step(($urandom % 200) == 0, ($urandom % 20) != 0, ($urandom % 6) == 0, lvl,
              (($urandom % 5) == 0) ? int'($urandom % 256) : int'($urandom % 12),
              $urandom % 2, 1'b1);
      end

      repeat (3) @(negedge clk);
      #4;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
